// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronizes UART_RXD, recovers frames and emits one-cycle DONE/FERR/PERR pulses.
// Optional parity check (8E1/8O1 selected by PARITY_ODD) is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UART_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_DONE,
  output logic       RX_FERR,
  output logic       RX_PERR
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_framer: illegal CLKS_PER_BIT or PARITY_ODD");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            sync1_q, sync2_q, rxs_prev_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            done_q, ferr_q, perr_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
`endif
  logic            rxs;

  assign rxs = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      sync1_q    <= UART_RXD;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (rxs_prev_q && !rxs) state_q <= S_START;
        end

        // Sample mid start bit; a line already back high was only a glitch.
        S_START: begin
          if (baud_q == BAUD_HALF) begin
            baud_q <= '0;
            bit_q  <= '0;
            state_q <= rxs ? S_IDLE : S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= {rxs, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            par_bad_q <= rxs ^ (^shift_q) ^ PARITY_ODD[0];
            state_q   <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (rxs) begin
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_q <= 1'b1;
              end else begin
                data_q <= shift_q;
                done_q <= 1'b1;
              end
`else
              data_q <= shift_q;
              done_q <= 1'b1;
`endif
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        // Held-low line: stay here so a break reports a single framing error.
        S_BREAK: begin
          baud_q <= '0;
          if (rxs) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RX_DATA = data_q;
  assign RX_DONE = done_q;
  assign RX_FERR = ferr_q;
  assign RX_PERR = perr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer at CLKS_PER_BIT=8; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

  localparam int CPB = 8;
  localparam int POD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 79 + CPB;
`else
  localparam int LAT = 79;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_ferr, rx_perr;

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(POD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .UART_RXD (rxd),
    .RX_DATA  (rx_data),
    .RX_DONE  (rx_done),
    .RX_FERR  (rx_ferr),
    .RX_PERR  (rx_perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0=DONE 1=FERR 2=PERR
  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         chk_lat;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Drives one frame; pushes the expected response at the start edge when exp_kind >= 0.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par,
                            input int exp_kind, input logic [7:0] exp_data, input bit chk_lat);
    exp_t e;
    rxd = 1'b0;
    if (exp_kind >= 0) begin
      e.kind = exp_kind; e.data = exp_data; e.chk_lat = chk_lat; e.start = cyc;
      exp_q.push_back(e);
    end
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ POD[0] ^ flip_par;
    bit_wait();
`else
    if (flip_par) $display("note: parity flip ignored in 8N1 build");
`endif
    rxd = stop_bit;
    bit_wait();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'h00);
    chk({tag, "_done"}, 32'(rx_done), 32'h0);
    chk({tag, "_ferr"}, 32'(rx_ferr), 32'h0);
    chk({tag, "_perr"}, 32'(rx_perr), 32'h0);
  endtask

  // Monitor: pops and compares whenever the DUT raises any pulse.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_done || rx_ferr || rx_perr)) begin
        kind = rx_done ? 0 : (rx_ferr ? 1 : 2);
        $display("rx cyc=%0d done=%0b ferr=%0b perr=%0b data=%02h", cyc, rx_done, rx_ferr, rx_perr, rx_data);
        chk("one_hot_pulse", 32'(rx_done) + 32'(rx_ferr) + 32'(rx_perr), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse actual=kind%0d data=%02h required=no pulse", kind, rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'(kind), 32'(e.kind));
          chk("rx_data", 32'(rx_data), 32'(e.data));
          if (e.chk_lat) begin
            n_checks++;
            if (cyc - e.start < LAT - 1 || cyc - e.start > LAT + 1) begin
              n_fail++;
              $display("FAIL latency actual=%0d required=%0d+/-1", cyc - e.start, LAT);
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;

    // 1: single frame with latency check
    send_frame(8'hA5, 1'b1, 1'b0, 0, 8'hA5, 1'b1);
    bit_wait(); bit_wait();

    // 2: back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 8'h3C, 1'b1);
    bit_wait(); bit_wait();

    // 3: short glitch must be rejected, then a normal frame
    rxd = 1'b0;
    repeat (2) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (30) @(posedge clk); #1;
    chk("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
    send_frame(8'h55, 1'b1, 1'b0, 0, 8'h55, 1'b0);
    bit_wait();

    // 4: bad stop bit, break held 40 bits, then recovery
    send_frame(8'h81, 1'b0, 1'b0, 1, 8'h55, 1'b0);
    repeat (40) bit_wait();
    rxd = 1'b1;
    bit_wait(); bit_wait();
    send_frame(8'h42, 1'b1, 1'b0, 0, 8'h42, 1'b0);
    bit_wait();

    // 5: reset during data bit 4 of 0xF0 aborts the frame
    rxd = 1'b0;
    bit_wait();
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      bit_wait();
    end
    rxd = 1'b1;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk); #1;
    repeat (5) bit_wait();
`ifdef UART_RX_PARITY_EN
    bit_wait();
`endif
    bit_wait();
    send_frame(8'h0F, 1'b1, 1'b0, 0, 8'h0F, 1'b0);
    bit_wait();

`ifdef UART_RX_PARITY_EN
    // 6: even parity good and bad
    send_frame(8'h03, 1'b1, 1'b0, 0, 8'h03, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, 2, 8'h03, 1'b0);
    bit_wait();
`endif

    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_data_hold", 32'(rx_data),
`ifdef UART_RX_PARITY_EN
        32'h03
`else
        32'h0F
`endif
    );

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
